alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 121 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for a combinational ALU: accepts one decoded op per request,
// holds the ALU inputs for one execute cycle, and returns the captured result.
module alu_issue_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_opcode,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [15:0]      req_imm,
    output logic [31:0]      alu_srca,
    output logic [31:0]      alu_srcb,
    output logic [3:0]       alu_shift,
    output logic [2:0]       alu_control,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_taken,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    state_t state_q, state_d;

    logic [31:0]      srca_q, srcb_q, result_q;
    logic [3:0]       shift_q;
    logic [2:0]       control_q;
    logic             is_beq_q, is_bne_q, taken_q, illegal_q;
    logic [CNT_W-1:0] count_q;

    logic        dec_legal;
    logic [2:0]  dec_control;
    logic [31:0] dec_srcb;
    logic        accept;

    always_comb begin
        dec_legal   = 1'b1;
        dec_control = 3'b000;
        dec_srcb    = req_rs2;
        case (req_opcode)
            4'h0, 4'h1, 4'h2, 4'h3,
            4'h4, 4'h5, 4'h6, 4'h7: dec_control = req_opcode[2:0];
            4'h8:                   dec_srcb = {{16{req_imm[15]}}, req_imm};
            4'h9, 4'hA:             dec_control = 3'b111;
            default:                dec_legal = 1'b0;
        endcase
    end

    assign accept = (state_q == StIdle) && req_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req_valid) state_d = dec_legal ? StExec : StResp;
            StExec: state_d = StResp;
            StResp: if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srca_q    <= '0;
            srcb_q    <= '0;
            shift_q   <= '0;
            control_q <= 3'b000;
            is_beq_q  <= 1'b0;
            is_bne_q  <= 1'b0;
            result_q  <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            if (accept) begin
                if (dec_legal) begin
                    srca_q    <= req_rs1;
                    srcb_q    <= dec_srcb;
                    shift_q   <= req_imm[3:0];
                    control_q <= dec_control;
                    is_beq_q  <= (req_opcode == 4'h9);
                    is_bne_q  <= (req_opcode == 4'hA);
                end else begin
                    // ALU inputs keep their previous values for an illegal op
                    result_q  <= '0;
                    taken_q   <= 1'b0;
                    illegal_q <= 1'b1;
                end
            end
            if (state_q == StExec) begin
                result_q  <= alu_result;
                taken_q   <= (is_beq_q & alu_zero) | (is_bne_q & ~alu_zero);
                illegal_q <= 1'b0;
            end
            if ((state_q == StResp) && rsp_ready) count_q <= count_q + CNT_W'(1);
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign rsp_valid   = (state_q == StResp);
    assign alu_srca    = srca_q;
    assign alu_srcb    = srcb_q;
    assign alu_shift   = shift_q;
    assign alu_control = control_q;
    assign rsp_result  = result_q;
    assign rsp_taken   = taken_q;
    assign rsp_illegal = illegal_q;
    assign op_count    = count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU; a 2-bit-counter instance
// shares the stimulus to exercise op_count wrap.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_opcode = '0;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic [15:0] req_imm = '0;
    logic        rsp_ready = 1'b1;

    logic        req_ready, rsp_valid, rsp_taken, rsp_illegal, alu_zero;
    logic [31:0] alu_srca, alu_srcb, alu_result, rsp_result;
    logic [3:0]  alu_shift;
    logic [2:0]  alu_control;
    logic [15:0] op_count;

    logic        s_req_ready, s_rsp_valid, s_rsp_taken, s_rsp_illegal;
    logic [31:0] s_alu_srca, s_alu_srcb, s_rsp_result;
    logic [3:0]  s_alu_shift;
    logic [2:0]  s_alu_control;
    logic [1:0]  s_op_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    // Reference ALU; zero flag only meaningful for SUB
    always_comb begin
        case (alu_control)
            3'b000:  alu_result = alu_srca + alu_srcb;
            3'b001:  alu_result = alu_srca | alu_srcb;
            3'b010:  alu_result = alu_srca & alu_srcb;
            3'b011:  alu_result = alu_srca ^ alu_srcb;
            3'b100:  alu_result = ~(alu_srca | alu_srcb);
            3'b101:  alu_result = alu_srca << alu_shift;
            3'b110:  alu_result = (alu_srca << alu_shift) | (alu_srca >> (6'd32 - {2'b0, alu_shift}));
            default: alu_result = alu_srca - alu_srcb;
        endcase
        alu_zero = (alu_control == 3'b111) && (alu_result == 32'd0);
    end

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_shift(alu_shift),
        .alu_control(alu_control), .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal), .op_count(op_count)
    );

    alu_issue_ctrl #(.CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(s_req_ready), .req_opcode(req_opcode),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .alu_srca(s_alu_srca), .alu_srcb(s_alu_srcb), .alu_shift(s_alu_shift),
        .alu_control(s_alu_control), .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(s_rsp_result),
        .rsp_taken(s_rsp_taken), .rsp_illegal(s_rsp_illegal), .op_count(s_op_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [15:0] imm, input logic [2:0] ctrl,
                          input logic [31:0] e_srca, input logic [31:0] e_srcb,
                          input logic [3:0] e_shift, input logic [31:0] e_res,
                          input logic e_taken, input logic e_ill, input int e_lat);
        int lat = 0;
        wait_ready();
        req_opcode = op; req_rs1 = a; req_rs2 = b; req_imm = imm;
        req_valid = 1'b1; rsp_ready = 1'b1;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                req_valid = 1'b0;
                check({tag, "_ctrl"},  32'(alu_control), 32'(ctrl));
                check({tag, "_srca"},  alu_srca, e_srca);
                check({tag, "_srcb"},  alu_srcb, e_srcb);
                check({tag, "_shift"}, 32'(alu_shift), 32'(e_shift));
            end
        end while (!rsp_valid && lat < 8);
        check({tag, "_lat"},     32'(lat), 32'(e_lat));
        check({tag, "_result"},  rsp_result, e_res);
        check({tag, "_taken"},   32'(rsp_taken), 32'(e_taken));
        check({tag, "_illegal"}, 32'(rsp_illegal), 32'(e_ill));
        @(posedge clk); #1;
        exp_cnt++;
        check({tag, "_vld_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready"},    32'(req_ready), 32'd1);
        check({tag, "_count"},    32'(op_count), 32'(exp_cnt));
        check({tag, "_count2"},   32'(s_op_count), 32'(exp_cnt % 4));
    endtask

    initial begin
        int stray;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",   32'(req_ready), 32'd1);
        check("rst_valid",   32'(rsp_valid), 32'd0);
        check("rst_result",  rsp_result, 32'd0);
        check("rst_flags",   {30'd0, rsp_taken, rsp_illegal}, 32'd0);
        check("rst_alu",     alu_srca | alu_srcb | 32'(alu_shift) | 32'(alu_control), 32'd0);
        check("rst_count",   32'(op_count), 32'd0);
        rst_n = 1'b1;

        // Reset while in execute aborts the op
        @(posedge clk); #1;
        req_opcode = 4'h0; req_rs1 = 32'd5; req_rs2 = 32'd7; req_imm = '0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(rsp_valid), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_count", 32'(op_count), 32'd0);
        check("abort_srca",  alu_srca, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid) stray++;
        end
        check("abort_no_rsp", 32'(stray), 32'd0);

        //      tag     op     rs1           rs2           imm      ctrl    srca          srcb          sh    result        tk    il    lat
        run_op("add",   4'h0, 32'd5,        32'd7,        16'h0000, 3'b000, 32'd5,        32'd7,        4'h0, 32'd12,       1'b0, 1'b0, 2);
        run_op("beq_t", 4'h9, 32'h1234,     32'h1234,     16'h0000, 3'b111, 32'h1234,     32'h1234,     4'h0, 32'd0,        1'b1, 1'b0, 2);
        run_op("bne_f", 4'hA, 32'h1234,     32'h1234,     16'h0000, 3'b111, 32'h1234,     32'h1234,     4'h0, 32'd0,        1'b0, 1'b0, 2);
        run_op("beq_f", 4'h9, 32'd1,        32'd2,        16'h0000, 3'b111, 32'd1,        32'd2,        4'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 2);
        run_op("addi",  4'h8, 32'd10,       32'd3,        16'hFFFF, 3'b000, 32'd10,       32'hFFFFFFFF, 4'hF, 32'd9,        1'b0, 1'b0, 2);
        run_op("sll",   4'h5, 32'd1,        32'd0,        16'h0004, 3'b101, 32'd1,        32'd0,        4'h4, 32'd16,       1'b0, 1'b0, 2);
        run_op("rot",   4'h6, 32'h80000001, 32'd0,        16'h0001, 3'b110, 32'h80000001, 32'd0,        4'h1, 32'h00000003, 1'b0, 1'b0, 2);
        run_op("and",   4'h2, 32'hFF00FF00, 32'h0F0F0F0F, 16'h0000, 3'b010, 32'hFF00FF00, 32'h0F0F0F0F, 4'h0, 32'h0F000F00, 1'b0, 1'b0, 2);
        run_op("nor",   4'h4, 32'hF0F0F0F0, 32'h0F0F0F00, 16'h0000, 3'b100, 32'hF0F0F0F0, 32'h0F0F0F00, 4'h0, 32'h0000000F, 1'b0, 1'b0, 2);
        run_op("sub_z", 4'h7, 32'd5,        32'd5,        16'h0000, 3'b111, 32'd5,        32'd5,        4'h0, 32'd0,        1'b0, 1'b0, 2);
        // Illegal: ALU inputs keep the SUB values
        run_op("ill",   4'hC, 32'h55,       32'h66,       16'h0009, 3'b111, 32'd5,        32'd5,        4'h0, 32'd0,        1'b0, 1'b1, 1);

        // Backpressure with a second request pending
        wait_ready();
        rsp_ready = 1'b0;
        req_opcode = 4'h3; req_rs1 = 32'hF0F0; req_rs2 = 32'h0FF0; req_imm = '0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_opcode = 4'h1; req_rs1 = 32'h0FF0; req_rs2 = 32'hFF00;
        @(posedge clk); #1;
        check("bp_valid", 32'(rsp_valid), 32'd1);
        stray = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (!rsp_valid || req_ready || rsp_result !== 32'h0000FF00 || alu_control !== 3'b011)
                stray++;
        end
        check("bp_stable", 32'(stray), 32'd0);
        check("bp_result", rsp_result, 32'h0000FF00);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_cnt++;
        check("bp_hs_ready", 32'(req_ready), 32'd1);
        check("bp_hs_ctrl",  32'(alu_control), 32'b011);
        check("bp_count",    32'(op_count), 32'(exp_cnt));
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp2_ctrl", 32'(alu_control), 32'b001);
        check("bp2_srca", alu_srca, 32'h0FF0);
        @(posedge clk); #1;
        check("bp2_valid",  32'(rsp_valid), 32'd1);
        check("bp2_result", rsp_result, 32'h0000FFF0);
        @(posedge clk); #1;
        exp_cnt++;
        check("bp2_count",  32'(op_count), 32'(exp_cnt));
        check("bp2_count2", 32'(s_op_count), 32'(exp_cnt % 4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
